// File: rtl/mdu_pkg.sv
// Shared op codes, FSM states and op-decode helpers for the iterative multiply/divide unit.
package mdu_pkg;

    localparam int unsigned MDU_OP_W = 3;

    localparam logic [MDU_OP_W-1:0] MDU_OP_MULT  = 3'd0;
    localparam logic [MDU_OP_W-1:0] MDU_OP_MULTU = 3'd1;
    localparam logic [MDU_OP_W-1:0] MDU_OP_DIV   = 3'd2;
    localparam logic [MDU_OP_W-1:0] MDU_OP_DIVU  = 3'd3;
    localparam logic [MDU_OP_W-1:0] MDU_OP_MTHI  = 3'd4;
    localparam logic [MDU_OP_W-1:0] MDU_OP_MTLO  = 3'd5;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } mdu_state_e;

    function automatic logic op_is_muldiv(input logic [MDU_OP_W-1:0] op);
        return (op == MDU_OP_MULT) || (op == MDU_OP_MULTU) ||
               (op == MDU_OP_DIV)  || (op == MDU_OP_DIVU);
    endfunction

    function automatic logic op_is_signed(input logic [MDU_OP_W-1:0] op);
        return (op == MDU_OP_MULT) || (op == MDU_OP_DIV);
    endfunction

    function automatic logic op_is_div(input logic [MDU_OP_W-1:0] op);
        return (op == MDU_OP_DIV) || (op == MDU_OP_DIVU);
    endfunction

endpackage

// File: rtl/mdu_iter_if.sv
// Request/result bundle between the EX stage (master) and the multiply/divide unit (slave).
interface mdu_iter_if #(
    parameter int unsigned WIDTH = 32
) ();

    logic                         start;
    logic [mdu_pkg::MDU_OP_W-1:0] op;
    logic [WIDTH-1:0]             a;
    logic [WIDTH-1:0]             b;
    logic                         cancel;
    logic                         busy;
    logic                         done;
    logic [WIDTH-1:0]             hi;
    logic [WIDTH-1:0]             lo;

    modport master (
        output start, op, a, b, cancel,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, a, b, cancel,
        output busy, done, hi, lo
    );

endinterface

// File: rtl/mdu_abs_neg.sv
// Conditional two's-complement negate; used both for operand magnitudes and result sign fix.
module mdu_abs_neg #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             neg,
    input  logic [WIDTH-1:0] x,
    output logic [WIDTH-1:0] res_c
);

    assign res_c = neg ? (~x + WIDTH'(1)) : x;

endmodule

// File: rtl/mdu_iter.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers: one bit per cycle, then a sign-fix cycle.
module mdu_iter
    import mdu_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic      clk,
    input  logic      rst,
    mdu_iter_if.slave bus
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    mdu_state_e         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH:0]     acc_hi_q;
    logic [WIDTH-1:0]   acc_lo_q;
    logic [WIDTH-1:0]   opnd_q;
    logic               is_div_q, neg_q, rneg_q;
    logic [WIDTH-1:0]   hi_q, lo_q;
    logic               busy_q, done_q;

    logic               load, commit, wr_hi, wr_lo;
    logic               sign_a, sign_b;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [WIDTH:0]     mul_sum, div_shift, div_diff;
    logic               div_borrow;
    logic [WIDTH:0]     acc_hi_nx;
    logic [WIDTH-1:0]   acc_lo_nx;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo, rem;

    assign sign_a = op_is_signed(bus.op) & bus.a[WIDTH-1];
    assign sign_b = op_is_signed(bus.op) & bus.b[WIDTH-1];

    mdu_abs_neg #(.WIDTH(WIDTH)) u_abs_a (.neg(sign_a), .x(bus.a), .res_c(mag_a));
    mdu_abs_neg #(.WIDTH(WIDTH)) u_abs_b (.neg(sign_b), .x(bus.b), .res_c(mag_b));

    mdu_abs_neg #(.WIDTH(2*WIDTH)) u_fix_prod (
        .neg(neg_q), .x({acc_hi_q[WIDTH-1:0], acc_lo_q}), .res_c(prod)
    );
    mdu_abs_neg #(.WIDTH(WIDTH)) u_fix_quo (.neg(neg_q),  .x(acc_lo_q),            .res_c(quo));
    mdu_abs_neg #(.WIDTH(WIDTH)) u_fix_rem (.neg(rneg_q), .x(acc_hi_q[WIDTH-1:0]), .res_c(rem));

    // One iteration: shift-add (multiplier sits in acc_lo) or restoring step (dividend in acc_lo)
    always_comb begin
        mul_sum                = acc_hi_q + ({1'b0, opnd_q} & {(WIDTH+1){acc_lo_q[0]}});
        div_shift              = {acc_hi_q[WIDTH-1:0], acc_lo_q[WIDTH-1]};
        {div_borrow, div_diff} = {1'b0, div_shift} - {2'b00, opnd_q};
        if (is_div_q) begin
            acc_hi_nx = div_borrow ? div_shift : div_diff;
            acc_lo_nx = {acc_lo_q[WIDTH-2:0], ~div_borrow};
        end else begin
            acc_hi_nx = {1'b0, mul_sum[WIDTH:1]};
            acc_lo_nx = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next state and control strobes; cancel beats a FIX completion
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        commit  = 1'b0;
        wr_hi   = 1'b0;
        wr_lo   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.start && !bus.cancel) begin
                    if (op_is_muldiv(bus.op)) begin
                        load    = 1'b1;
                        state_d = S_CALC;
                    end else if (bus.op == MDU_OP_MTHI) begin
                        wr_hi = 1'b1;
                    end else if (bus.op == MDU_OP_MTLO) begin
                        wr_lo = 1'b1;
                    end
                end
            end
            S_CALC: begin
                if (bus.cancel)              state_d = S_IDLE;
                else if (cnt_q == CNT_LAST)  state_d = S_FIX;
            end
            S_FIX: begin
                state_d = S_IDLE;
                commit  = !bus.cancel;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= '0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            opnd_q   <= '0;
            is_div_q <= 1'b0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            busy_q <= (state_d != S_IDLE);
            done_q <= commit;
            if (wr_hi) hi_q <= bus.a;
            if (wr_lo) lo_q <= bus.a;
            if (commit) begin
                hi_q <= is_div_q ? rem : prod[2*WIDTH-1:WIDTH];
                lo_q <= is_div_q ? quo : prod[WIDTH-1:0];
            end
            if (load) begin
                cnt_q    <= '0;
                is_div_q <= op_is_div(bus.op);
                neg_q    <= sign_a ^ sign_b;
                rneg_q   <= sign_a;
                acc_hi_q <= '0;
                opnd_q   <= op_is_div(bus.op) ? mag_b : mag_a;
                acc_lo_q <= op_is_div(bus.op) ? mag_a : mag_b;
            end else if (state_q == S_CALC) begin
                cnt_q    <= cnt_q + CNT_W'(1);
                acc_hi_q <= acc_hi_nx;
                acc_lo_q <= acc_lo_nx;
            end
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;

endmodule
